// File: rtl/jtkunio_gfx_pkg.sv
// Shared constants for the Kunio graphics ROM arbiter: requester ids,
// arbiter state encoding and the default ROM region offsets.
package jtkunio_gfx_pkg;

  // Requester identifiers, also the fixed priority order (lowest wins).
  localparam logic [1:0] ID_SCR = 2'd0;
  localparam logic [1:0] ID_OBJ = 2'd1;
  localparam logic [1:0] ID_CHR = 2'd2;

  // Arbiter FSM states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  // Default base of each layer inside the 18-bit ROM word space.
  localparam logic [17:0] DEF_SCR_OFFSET = 18'h00000;
  localparam logic [17:0] DEF_OBJ_OFFSET = 18'h20000;
  localparam logic [17:0] DEF_CHR_OFFSET = 18'h30000;

endpackage

// File: rtl/jtkunio_gfx_slot.sv
// One-entry cache for a single tile fetcher. Remembers the last fetched
// address and word, reports a hit as ok and a miss as pending.
module jtkunio_gfx_slot
  import jtkunio_gfx_pkg::*;
(
  input  logic        rst,
  input  logic        clk,
  input  logic        cs,
  input  logic [16:0] addr,
  input  logic        clr,        // arbiter picked this slot: drop the entry
  input  logic        fill,       // downstream word arrived for this slot
  input  logic [16:0] fill_addr,
  input  logic [31:0] fill_data,
  output logic [31:0] data,
  output logic        ok,
  output logic        pending
);

  logic [16:0] last_q, last_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        hit;

  // Entry update: a fill wins over a clear (they never coincide in practice).
  always_comb begin
    last_d  = last_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
    end
    if (fill) begin
      valid_d = 1'b1;
      last_d  = fill_addr;
      data_d  = fill_data;
    end
  end

  // Entry registers, cleared asynchronously so no stale word survives reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      last_q  <= last_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // The stored word is only ever flagged against the address it came from.
  assign hit     = valid_q & (addr == last_q);
  assign ok      = cs & hit;
  assign pending = cs & ~hit;
  assign data    = data_q;

endmodule

// File: rtl/jtkunio_gfx_arb.sv
// Shares one 32-bit graphics ROM port between the scroll, object and char
// tile fetchers. Fixed priority scr > obj > chr; each layer sees its own
// cached address/data/ok interface.
module jtkunio_gfx_arb
  import jtkunio_gfx_pkg::*;
#(
  parameter int            AW         = 18,
  parameter logic [AW-1:0] SCR_OFFSET = DEF_SCR_OFFSET,
  parameter logic [AW-1:0] OBJ_OFFSET = DEF_OBJ_OFFSET,
  parameter logic [AW-1:0] CHR_OFFSET = DEF_CHR_OFFSET
) (
  input  logic          rst,
  input  logic          clk,
  input  logic [16:0]   scr_addr,
  input  logic          scr_cs,
  output logic [31:0]   scr_data,
  output logic          scr_ok,
  input  logic [16:0]   obj_addr,
  input  logic          obj_cs,
  output logic [31:0]   obj_data,
  output logic          obj_ok,
  input  logic [14:0]   chr_addr,
  input  logic          chr_cs,
  output logic [31:0]   chr_data,
  output logic          chr_ok,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [31:0]   rom_data,
  input  logic          rom_ok
);

  logic [1:0]    state_q, state_d;
  logic [1:0]    id_q, id_d;
  logic [16:0]   lat_q, lat_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          rom_cs_q, rom_cs_d;

  logic [16:0]   chr_addr_ext;
  logic          scr_pend, obj_pend, chr_pend;
  logic          scr_clr, obj_clr, chr_clr;
  logic          done;

  assign chr_addr_ext = {2'b00, chr_addr};

  // A fill happens on the cycle WAIT sees rom_ok; SETTLE masks stale ok.
  assign done = (state_q == ST_WAIT) & rom_ok;

  // Arbiter next-state: pick a pending layer, then hold until rom_ok.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    lat_d      = lat_q;
    rom_addr_d = rom_addr_q;
    rom_cs_d   = rom_cs_q;
    scr_clr    = 1'b0;
    obj_clr    = 1'b0;
    chr_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rom_cs_d = 1'b0;
        if (scr_pend) begin
          id_d       = ID_SCR;
          lat_d      = scr_addr;
          rom_addr_d = SCR_OFFSET + AW'(scr_addr);
          rom_cs_d   = 1'b1;
          scr_clr    = 1'b1;
          state_d    = ST_SETTLE;
        end else if (obj_pend) begin
          id_d       = ID_OBJ;
          lat_d      = obj_addr;
          rom_addr_d = OBJ_OFFSET + AW'(obj_addr);
          rom_cs_d   = 1'b1;
          obj_clr    = 1'b1;
          state_d    = ST_SETTLE;
        end else if (chr_pend) begin
          id_d       = ID_CHR;
          lat_d      = chr_addr_ext;
          rom_addr_d = CHR_OFFSET + AW'(chr_addr_ext);
          rom_cs_d   = 1'b1;
          chr_clr    = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rom_ok) begin
          rom_cs_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        rom_cs_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Arbiter registers; reset drops rom_cs at once, even mid-transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      id_q       <= ID_SCR;
      lat_q      <= '0;
      rom_addr_q <= '0;
      rom_cs_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      lat_q      <= lat_d;
      rom_addr_q <= rom_addr_d;
      rom_cs_q   <= rom_cs_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rom_cs   = rom_cs_q;

  jtkunio_gfx_slot u_scr (
    .rst       (rst),
    .clk       (clk),
    .cs        (scr_cs),
    .addr      (scr_addr),
    .clr       (scr_clr),
    .fill      (done & (id_q == ID_SCR)),
    .fill_addr (lat_q),
    .fill_data (rom_data),
    .data      (scr_data),
    .ok        (scr_ok),
    .pending   (scr_pend)
  );

  jtkunio_gfx_slot u_obj (
    .rst       (rst),
    .clk       (clk),
    .cs        (obj_cs),
    .addr      (obj_addr),
    .clr       (obj_clr),
    .fill      (done & (id_q == ID_OBJ)),
    .fill_addr (lat_q),
    .fill_data (rom_data),
    .data      (obj_data),
    .ok        (obj_ok),
    .pending   (obj_pend)
  );

  jtkunio_gfx_slot u_chr (
    .rst       (rst),
    .clk       (clk),
    .cs        (chr_cs),
    .addr      (chr_addr_ext),
    .clr       (chr_clr),
    .fill      (done & (id_q == ID_CHR)),
    .fill_addr (lat_q),
    .fill_data (rom_data),
    .data      (chr_data),
    .ok        (chr_ok),
    .pending   (chr_pend)
  );

endmodule

// File: tb/tb_jtkunio_gfx_arb.sv
// Bench for the graphics ROM arbiter: directed scenarios followed by a
// randomized run checked against a transaction-level cache/priority model.
module tb_jtkunio_gfx_arb;

  logic        rst, clk;
  logic [16:0] scr_addr, obj_addr;
  logic [14:0] chr_addr;
  logic        scr_cs, obj_cs, chr_cs;
  logic [31:0] scr_data, obj_data, chr_data;
  logic        scr_ok, obj_ok, chr_ok;
  logic [17:0] rom_addr;
  logic        rom_cs;
  logic [31:0] rom_data;
  logic        rom_ok;

  logic [31:0] w_scr_data, w_obj_data, w_chr_data;
  logic        w_scr_ok, w_obj_ok, w_chr_ok;
  logic [17:0] w_rom_addr;
  logic        w_rom_cs;

  int checks = 0;
  int errors = 0;

  jtkunio_gfx_arb dut (
    .rst(rst), .clk(clk),
    .scr_addr(scr_addr), .scr_cs(scr_cs), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_data(obj_data), .obj_ok(obj_ok),
    .chr_addr(chr_addr), .chr_cs(chr_cs), .chr_data(chr_data), .chr_ok(chr_ok),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  jtkunio_gfx_arb #(.OBJ_OFFSET(18'h3FFFF)) u_wrap (
    .rst(rst), .clk(clk),
    .scr_addr(scr_addr), .scr_cs(scr_cs), .scr_data(w_scr_data), .scr_ok(w_scr_ok),
    .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_data(w_obj_data), .obj_ok(w_obj_ok),
    .chr_addr(chr_addr), .chr_cs(chr_cs), .chr_data(w_chr_data), .chr_ok(w_chr_ok),
    .rom_addr(w_rom_addr), .rom_cs(w_rom_cs), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [17:0] a);
    return {a ^ 18'h2A5A5, a[13:0] ^ 14'h1234};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Downstream answer: SETTLE cycle, k extra WAIT cycles, then one ok cycle.
  task automatic serve(input int k, input logic [31:0] d);
    cyc();
    repeat (k) cyc();
    rom_ok   = 1'b1;
    rom_data = d;
    cyc();
    rom_ok   = 1'b0;
  endtask

  // Reference model state
  logic [17:0] off [3];
  logic [16:0] m_last [3];
  bit          m_valid [3];
  logic [16:0] in_addr [3];
  bit          in_cs [3];
  logic        obs_ok [3];
  logic [31:0] obs_data [3];
  int          cur_r, exp_r, cnt, dly;
  logic [16:0] cur_a;
  bit          comp_pend, idle_prev;

  initial begin
    off[0] = 18'h00000; off[1] = 18'h20000; off[2] = 18'h30000;
    rst = 1'b1;
    scr_addr = '0; obj_addr = '0; chr_addr = '0;
    scr_cs = 1'b1; obj_cs = 1'b0; chr_cs = 1'b0;
    rom_data = '0; rom_ok = 1'b0;

    // Reset state
    #3;
    chk("rst_rom_cs", rom_cs, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_scr_ok", scr_ok, 0);
    chk("rst_scr_data", scr_data, 0);
    chk("rst_obj_data", obj_data, 0);
    chk("rst_chr_data", chr_data, 0);
    scr_cs = 1'b0;
    cyc();
    rst = 1'b0;

    // Single scroll miss, rom_ok two cycles after SETTLE
    scr_addr = 17'h00123; scr_cs = 1'b1;
    cyc();
    chk("lat_start_cs", rom_cs, 1);
    chk("lat_start_addr", rom_addr, 18'h00123);
    chk("lat_c1_ok", scr_ok, 0);
    cyc();
    chk("lat_c2_cs", rom_cs, 1);
    chk("lat_c2_ok", scr_ok, 0);
    cyc();
    chk("lat_c3_ok", scr_ok, 0);
    cyc();
    chk("lat_c4_cs", rom_cs, 1);
    chk("lat_c4_ok", scr_ok, 0);
    rom_ok = 1'b1; rom_data = 32'hCAFE0123;
    cyc();
    rom_ok = 1'b0;
    chk("lat_c5_ok", scr_ok, 1);
    chk("lat_c5_data", scr_data, 32'hCAFE0123);
    chk("lat_c5_cs", rom_cs, 0);

    // Cache hit: no new downstream request
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("hit_ok", scr_ok, 1);
      chk("hit_rom_cs", rom_cs, 0);
    end

    // Three simultaneous misses served in priority order
    scr_addr = 17'h00010; obj_addr = 17'h00010; chr_addr = 15'h0010;
    obj_cs = 1'b1; chr_cs = 1'b1;
    cyc();
    chk("pri1_addr", rom_addr, 18'h00010);
    chk("pri1_cs", rom_cs, 1);
    serve(0, 32'h11111111);
    chk("pri1_scr_ok", scr_ok, 1);
    chk("pri1_scr_data", scr_data, 32'h11111111);
    chk("pri1_obj_ok", obj_ok, 0);
    chk("pri1_chr_ok", chr_ok, 0);
    cyc();
    chk("pri2_addr", rom_addr, 18'h20010);
    serve(1, 32'h22222222);
    chk("pri2_obj_ok", obj_ok, 1);
    chk("pri2_obj_data", obj_data, 32'h22222222);
    chk("pri2_chr_ok", chr_ok, 0);
    cyc();
    chk("pri3_addr", rom_addr, 18'h30010);
    serve(2, 32'h33333333);
    chk("pri3_chr_ok", chr_ok, 1);
    chk("pri3_chr_data", chr_data, 32'h33333333);
    chk("pri3_scr_ok", scr_ok, 1);

    // Address change while the fetch is in WAIT
    obj_cs = 1'b0; chr_cs = 1'b0;
    scr_addr = 17'h00040;
    cyc();
    chk("chg_addr1", rom_addr, 18'h00040);
    cyc();
    scr_addr = 17'h00041;
    rom_ok = 1'b1; rom_data = 32'h40404040;
    cyc();
    rom_ok = 1'b0;
    chk("chg_ok_after_fill", scr_ok, 0);
    chk("chg_cs_idle", rom_cs, 0);
    cyc();
    chk("chg_addr2", rom_addr, 18'h00041);
    chk("chg_cs2", rom_cs, 1);
    serve(1, 32'h41414141);
    chk("chg_ok2", scr_ok, 1);
    chk("chg_data2", scr_data, 32'h41414141);

    // Stale rom_ok through SETTLE, then reset mid-WAIT
    obj_cs = 1'b1; obj_addr = 17'h00010;
    chr_cs = 1'b1; chr_addr = 15'h0010;
    scr_addr = 17'h00050;
    rom_ok = 1'b1; rom_data = 32'hDEADBEEF;
    cyc();
    chk("stale_settle_cs", rom_cs, 1);
    chk("stale_settle_ok", scr_ok, 0);
    cyc();
    rom_ok = 1'b0;
    chk("stale_wait_cs", rom_cs, 1);
    chk("stale_wait_ok", scr_ok, 0);
    chk("stale_obj_hit", obj_ok, 1);
    cyc();
    chk("stale_hold_cs", rom_cs, 1);
    rst = 1'b1;
    #1;
    chk("rstw_rom_cs", rom_cs, 0);
    chk("rstw_rom_addr", rom_addr, 0);
    chk("rstw_scr_ok", scr_ok, 0);
    chk("rstw_obj_ok", obj_ok, 0);
    chk("rstw_chr_ok", chr_ok, 0);
    cyc();

    // Offset wrap-around on the object port
    scr_cs = 1'b0; chr_cs = 1'b0;
    obj_cs = 1'b1; obj_addr = 17'h1FFFF;
    rst = 1'b0;
    cyc();
    chk("wrap_addr", w_rom_addr, 18'h1FFFE);
    chk("wrap_cs", w_rom_cs, 1);
    chk("nowrap_addr", rom_addr, 18'h3FFFF);
    serve(0, 32'h0BADF00D);
    chk("wrap_obj_ok", w_obj_ok, 1);

    // Randomized run against the model
    rst = 1'b1;
    scr_cs = 1'b0; obj_cs = 1'b0; chr_cs = 1'b0;
    for (int r = 0; r < 3; r++) begin
      m_valid[r] = 0; m_last[r] = '0; in_cs[r] = 0; in_addr[r] = '0;
    end
    cyc();
    rst = 1'b0;
    comp_pend = 0; idle_prev = 0; exp_r = -1; cur_r = 0; cur_a = '0; cnt = 0; dly = 0;
    for (int it = 0; it < 600; it++) begin
      if (comp_pend) begin
        m_valid[cur_r] = 1;
        m_last[cur_r]  = cur_a;
        comp_pend = 0;
      end
      if (idle_prev) begin
        if (exp_r < 0) begin
          chk("rnd_idle_cs", rom_cs, 0);
        end else begin
          chk("rnd_start_cs", rom_cs, 1);
          chk("rnd_start_addr", rom_addr, off[exp_r] + {1'b0, cur_a});
          m_valid[exp_r] = 0;
          cur_r = exp_r;
          cnt = 0;
          dly = $urandom_range(0, 3);
        end
      end
      for (int r = 0; r < 3; r++) begin
        if ($urandom_range(0, 5) == 0) in_addr[r] = 17'($urandom_range(0, 3) * (r + 1) * 17'h0111);
        if ($urandom_range(0, 9) == 0) in_cs[r] = ~in_cs[r];
      end
      scr_addr = in_addr[0]; scr_cs = in_cs[0];
      obj_addr = in_addr[1]; obj_cs = in_cs[1];
      chr_addr = in_addr[2][14:0]; chr_cs = in_cs[2];
      if (rom_cs) begin
        cnt++;
        rom_ok   = (cnt >= 2 + dly);
        rom_data = rom_word(rom_addr);
      end else begin
        rom_ok = 1'b0;
      end
      #1;
      obs_ok[0] = scr_ok; obs_ok[1] = obj_ok; obs_ok[2] = chr_ok;
      obs_data[0] = scr_data; obs_data[1] = obj_data; obs_data[2] = chr_data;
      for (int r = 0; r < 3; r++) begin
        bit hit;
        hit = in_cs[r] && m_valid[r] && (in_addr[r] == m_last[r]);
        chk("rnd_ok", obs_ok[r], hit);
        if (hit) chk("rnd_data", obs_data[r], rom_word(off[r] + {1'b0, m_last[r]}));
      end
      idle_prev = !rom_cs;
      exp_r = -1;
      if (!rom_cs) begin
        for (int r = 2; r >= 0; r--) begin
          if (in_cs[r] && !(m_valid[r] && in_addr[r] == m_last[r])) begin
            exp_r = r;
            cur_a = in_addr[r];
          end
        end
      end
      comp_pend = rom_cs && rom_ok;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtkunio_gfx_arb.md
Name: jtkunio_gfx_arb

Overview:
- Shares one 32-bit graphics ROM port (SDRAM bank slot) between three tile fetchers: scroll, object and character layers.
- Each requester keeps its own address, data and ok handshake, so layers need no knowledge of sharing.
- Per-requester one-entry cache: a repeated address returns ok without a new fetch.
- Sits between the video layer modules and the SDRAM/ROM bank controller in the game top level.

Parameters:
- AW, 18, downstream word address width.
- SCR_OFFSET, 18'h00000, base added to scroll address.
- OBJ_OFFSET, 18'h20000, base added to object address.
- CHR_OFFSET, 18'h30000, base added to char address.

Ports:
- rst  in  1  asynchronous reset, active-high.
- clk  in  1  system clock.
- scr_addr  in  17  scroll word address.
- scr_cs  in  1  scroll request enable.
- scr_data  out  32  scroll data.
- scr_ok  out  1  scroll data valid for the current scr_addr.
- obj_addr  in  17  object word address.
- obj_cs  in  1  object request enable.
- obj_data  out  32  object data.
- obj_ok  out  1  object data valid.
- chr_addr  in  15  char word address, zero-extended to 17 bits.
- chr_cs  in  1  char request enable.
- chr_data  out  32  char data.
- chr_ok  out  1  char data valid.
- rom_addr  out  AW  downstream address.
- rom_cs  out  1  downstream request.
- rom_data  in  32  downstream data.
- rom_ok  in  1  downstream data valid; may stay stale-high for 1 cycle after an address change.

Behaviour:
- Reset (async) values:
  - state=IDLE, rom_cs=0, rom_addr=0.
  - All *_data=0, all cached addresses=0, all valid flags=0, so all *_ok=0.
- Per requester x:
  - Registered last_x (17b) and valid_x.
  - x_ok = x_cs & valid_x & (x_addr==last_x), combinational.
  - x_data holds the last fetched word.
  - Pending condition: x_cs & ~(valid_x & x_addr==last_x).
- FSM:
  - IDLE: choose the highest-priority pending requester, fixed order scr > obj > chr.
    - Latch requester id and its address.
    - rom_addr <= offset_x + {zero-extended address}, truncated to AW (wrap-around, no carry out).
    - rom_cs <= 1; valid_x <= 0; go to SETTLE.
    - If nothing is pending, stay in IDLE with rom_cs=0.
  - SETTLE: one cycle; rom_ok is ignored. Go to WAIT.
  - WAIT: hold rom_cs and rom_addr until rom_ok=1. On that cycle:
    - x_data <= rom_data, last_x <= latched address, valid_x <= 1.
    - rom_cs <= 0; go to IDLE.
- Latency:
  - Cache hit: x_ok the same cycle (0 clocks).
  - Miss with an idle arbiter and rom_ok returned k cycles after SETTLE: x_ok high k+3 cycles after the address is presented. A busy arbiter adds the current transfer's remaining time.
- Address change mid-fetch:
  - The fetch completes with the latched address and stores it.
  - The requester sees x_ok=0 because its address no longer matches, and a new request is scheduled.
  - The returned data is never presented against the wrong address.
- x_cs dropped mid-fetch: the fetch completes and fills the cache; no abort.
- Simultaneous completion and new request from the same requester: the next IDLE cycle re-evaluates pending using the updated last_x.
- No round robin:
  - chr can starve only while scr/obj miss continuously.
  - Scroll fetches occur at most once per 8 pixels, so the bandwidth is bounded by design.
- Reset during WAIT: returns to IDLE, rom_cs drops immediately, caches are invalidated.

Decomposition:
- Shared package jtkunio_gfx_pkg:
  - requester id encoding ID_SCR=0, ID_OBJ=1, ID_CHR=2.
  - state encoding IDLE/SETTLE/WAIT.
  - default offsets.
- Natural sub-module jtkunio_gfx_slot, instantiated 3x:
  - Holds last/valid/data.
  - Computes ok and pending.
  - Accepts a fill strobe from the arbiter.
- The arbiter FSM stays in the top module.

Test Plan:
- Reset, then scr_cs=1 with scr_addr=17'h00123 and rom_ok returned 2 cycles after SETTLE:
  - rom_addr=18'h00123, rom_cs high until rom_ok.
  - scr_data equals rom_data and scr_ok=1 at cycle 5.
  - rom_cs=0 afterwards.
- scr_addr held at 17'h00123 after the fill: scr_ok stays 1 and rom_cs never reasserts (cache hit).
- scr, obj and chr all miss in the same cycle:
  - Downstream order is scr (18'h00010), obj (18'h20010), chr (18'h30010).
  - Each *_ok rises only after its own fill.
- obj_addr=17'h1FFFF with OBJ_OFFSET=18'h3FFFF: rom_addr=18'h1FFFE (wrap).
- scr_addr changed from 17'h00040 to 17'h00041 during WAIT:
  - scr_ok stays 0 after the fill of 00040.
  - A second fetch to 00041 follows, then scr_ok=1.
- Stale rom_ok=1 held through SETTLE: data is not captured until WAIT. Then assert rst mid-WAIT: rom_cs=0 and all *_ok=0 immediately.
